// File: rtl/des_decrypt_core.sv
// Iterative DES decryption core: one Feistel round per clock, subkeys produced
// on the fly by rotating C and D right so K16 comes first and K1 last.
module des_decrypt_core #(
  parameter bit CHECK_PARITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:64] ct,
  input  logic [1:64] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:64] pt,
  output logic        busy,
  output logic        key_err
);

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
    26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
    51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // Each S-box is stored row-major: index = {b1,b6} * 16 + {b2..b5}.
  localparam int S_T [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t      state;
  logic [1:32] l_q, r_q;
  logic [1:28] c_q, d_q;
  logic [4:0]  rnd;

  logic [1:64] ip_ct, rl_new, fp_out;
  logic [1:56] pc1_key, cd_rot;
  logic [1:28] c_rot, d_rot;
  logic [1:48] subkey, e_r, s_in;
  logic [1:32] s_out, f_out, r_new;
  logic [7:0]  byte_even;

  // Right-rotation schedule that walks the encryption shifts backwards.
  always_comb begin
    c_rot = c_q;
    d_rot = d_q;
    case (rnd)
      5'd1: begin
        c_rot = c_q;
        d_rot = d_q;
      end
      5'd2, 5'd9, 5'd16: begin
        c_rot = {c_q[28], c_q[1:27]};
        d_rot = {d_q[28], d_q[1:27]};
      end
      default: begin
        c_rot = {c_q[27:28], c_q[1:26]};
        d_rot = {d_q[27:28], d_q[1:26]};
      end
    endcase
  end

  assign cd_rot = {c_rot, d_rot};
  assign s_in   = e_r ^ subkey;
  assign r_new  = l_q ^ f_out;
  assign rl_new = {r_new, r_q};

  for (genvar i = 0; i < 64; i++) begin : g_p64
    assign ip_ct[i+1]  = ct[IP_T[i]];
    assign fp_out[i+1] = rl_new[FP_T[i]];
  end
  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1_key[i+1] = key[PC1_T[i]];
  end
  for (genvar i = 0; i < 48; i++) begin : g_p48
    assign subkey[i+1] = cd_rot[PC2_T[i]];
    assign e_r[i+1]    = r_q[E_T[i]];
  end
  for (genvar i = 0; i < 32; i++) begin : g_p32
    assign f_out[i+1] = s_out[P_T[i]];
  end
  for (genvar j = 0; j < 8; j++) begin : g_sbox
    logic [5:0] six;
    assign six = s_in[6*j+1 +: 6];
    assign s_out[4*j+1 +: 4] = 4'(S_T[j][{six[5], six[0], six[4:1]}]);
    assign byte_even[j] = ~^key[8*j+1 +: 8];
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state == ROUND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      l_q       <= '0;
      r_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      rnd       <= '0;
      pt        <= '0;
      out_valid <= 1'b0;
      key_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            {l_q, r_q} <= ip_ct;
            {c_q, d_q} <= pc1_key;
            rnd        <= 5'd1;
            key_err    <= CHECK_PARITY ? (|byte_even) : 1'b0;
            state      <= ROUND;
          end
        end
        ROUND: begin
          l_q <= r_q;
          r_q <= r_new;
          c_q <= c_rot;
          d_q <= d_rot;
          if (rnd == 5'd16) begin
            pt        <= fp_out;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            rnd <= rnd + 5'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed bench for des_decrypt_core: known-answer jobs, back-pressure, parity,
// mid-job reset and back-to-back throughput; edges are numbered with acceptance = 1.
module tb_des_decrypt_core;

  localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
  localparam logic [63:0] CT_A    = 64'h85E813540F0AB405;
  localparam logic [63:0] PT_A    = 64'h0123456789ABCDEF;
  localparam logic [63:0] KEY_B   = 64'h0E329232EA6D0D73;
  localparam logic [63:0] CT_B    = 64'h0000000000000000;
  localparam logic [63:0] PT_B    = 64'h8787878787878787;
  localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [1:64] ct;
  logic [1:64] key;
  logic        in_ready, out_valid, busy, key_err;
  logic [1:64] pt;
  logic        np_in_ready, np_out_valid, np_busy, np_key_err;
  logic [1:64] np_pt;

  int n_cmp  = 0;
  int n_fail = 0;

  des_decrypt_core #(.CHECK_PARITY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ct(ct), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .pt(pt), .busy(busy), .key_err(key_err)
  );

  des_decrypt_core #(.CHECK_PARITY(1'b0)) dut_np (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(np_in_ready),
    .ct(ct), .key(key), .out_valid(np_out_valid), .out_ready(out_ready),
    .pt(np_pt), .busy(np_busy), .key_err(np_key_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] c, input logic [63:0] k,
                               input logic rdy);
    in_valid  = v;
    ct        = c;
    key       = k;
    out_ready = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic runJob(input string tag, input logic [63:0] c, input logic [63:0] k,
                        input logic [63:0] exp_pt, input logic exp_err, input logic rdy);
    int edge_no;
    int busy_cnt;
    applyStimulus(1'b1, c, k, rdy);
    tick();
    applyStimulus(1'b0, ~c, ~k, rdy);
    edge_no  = 1;
    busy_cnt = busy ? 1 : 0;
    while (!out_valid && edge_no < 40) begin
      tick();
      edge_no++;
      if (busy) busy_cnt++;
    end
    checkOutput({tag, " out_valid edge"}, 64'(edge_no), 64'd17);
    checkOutput({tag, " busy cycles"}, 64'(busy_cnt), 64'd16);
    checkOutput({tag, " pt"}, pt, exp_pt);
    checkOutput({tag, " key_err"}, 64'(key_err), 64'(exp_err));
    checkOutput({tag, " pt no-parity"}, np_pt, exp_pt);
    checkOutput({tag, " key_err no-parity"}, 64'(np_key_err), 64'd0);
  endtask

  initial begin
    int          edge_no;
    bit          seen;
    logic [63:0] exp_pt;

    rst_n = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset key_err", 64'(key_err), 64'd0);
    checkOutput("reset pt", pt, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("idle in_ready", 64'(in_ready), 64'd1);

    $display("[TB] known-answer A");
    runJob("kat_a", CT_A, KEY_A, PT_A, 1'b0, 1'b1);
    tick();
    checkOutput("kat_a release out_valid", 64'(out_valid), 64'd0);
    checkOutput("kat_a release in_ready", 64'(in_ready), 64'd1);
    checkOutput("kat_a pt retained", pt, PT_A);

    $display("[TB] known-answer B with back-pressure");
    runJob("kat_b", CT_B, KEY_B, PT_B, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, CT_A, KEY_BAD, 1'b0);
      tick();
      checkOutput("hold out_valid", 64'(out_valid), 64'd1);
      checkOutput("hold pt", pt, PT_B);
      checkOutput("hold key_err", 64'(key_err), 64'd0);
      checkOutput("hold in_ready", 64'(in_ready), 64'd0);
    end
    applyStimulus(1'b0, CT_A, KEY_BAD, 1'b1);
    tick();
    checkOutput("drain out_valid", 64'(out_valid), 64'd0);
    checkOutput("drain in_ready", 64'(in_ready), 64'd1);
    checkOutput("drain busy", 64'(busy), 64'd0);
    checkOutput("drain pt retained", pt, PT_B);

    $display("[TB] parity checks");
    runJob("parity_bad", CT_A, KEY_BAD, PT_A, 1'b1, 1'b1);
    tick();
    runJob("parity_good", CT_A, KEY_A, PT_A, 1'b0, 1'b1);
    tick();

    $display("[TB] reset during round 8");
    applyStimulus(1'b1, CT_B, KEY_BAD, 1'b1);
    tick();
    applyStimulus(1'b0, CT_B, KEY_BAD, 1'b1);
    repeat (7) tick();
    checkOutput("pre-reset busy", 64'(busy), 64'd1);
    checkOutput("pre-reset key_err", 64'(key_err), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort in_ready", 64'(in_ready), 64'd1);
    checkOutput("abort key_err", 64'(key_err), 64'd0);
    checkOutput("abort pt", pt, 64'd0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checkOutput("abort no out_valid", 64'(seen), 64'd0);
    runJob("after_reset", CT_A, KEY_A, PT_A, 1'b0, 1'b1);
    tick();

    $display("[TB] back-to-back jobs");
    applyStimulus(1'b1, CT_A, KEY_A, 1'b1);
    tick();
    for (int j = 0; j < 4; j++) begin
      exp_pt = (j % 2 == 0) ? PT_A : PT_B;
      if (j % 2 == 0) applyStimulus(1'b1, CT_B, KEY_B, 1'b1);
      else            applyStimulus(1'b1, CT_A, KEY_A, 1'b1);
      edge_no = 1;
      while (!out_valid && edge_no < 40) begin
        tick();
        edge_no++;
      end
      checkOutput("b2b out_valid edge", 64'(edge_no), 64'd17);
      checkOutput("b2b pt", pt, exp_pt);
      while (!busy && edge_no < 60) begin
        tick();
        edge_no++;
      end
      checkOutput("b2b next acceptance edge", 64'(edge_no), 64'd19);
    end
    applyStimulus(1'b0, '0, '0, 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
